write_out_sequencer: RTL
========================

WRITE_OUT_SEQUENCER -- requirements
Module: write_out_sequencer

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 16, the systolic array dimension; one tile = 2*ARRAY_SIZE-1 diagonal writes.
REQ-002 SHALL have parameter DRAIN_LATENCY, default 3, the idle cycles between start acceptance and the first write (range 0..63).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 srstn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  tile request; accepted when start_ready=1.
REQ-006 set_sel  input  2  data set of the requested tile; sampled with accepted start.
REQ-007 stall  input  1  downstream hold; freezes sequencing in the same cycle.
REQ-008 start_ready  output  1  high when a start would be accepted (pending slot empty).
REQ-009 busy  output  1  high in WAIT, WRITE and DONE states.
REQ-010 done  output  1  one-cycle pulse after the last write of a tile.
REQ-011 err  output  1  one-cycle pulse when an accepted start carries set_sel>1.
REQ-012 sram_write_enable  output  1  active-high write strobe to the write-out stage.
REQ-013 data_set  output  2  data set of the tile in progress.
REQ-014 matrix_index  output  6  diagonal index of the current write, 0..2*ARRAY_SIZE-2.

Function
REQ-015 FSM states: IDLE, WAIT, WRITE, DONE; state, wait counter, index counter, data_set and a one-deep pending slot (valid + set) SHALL be registers.
REQ-016 Accepted start with set_sel<=1: in IDLE, next state WAIT (or WRITE if DRAIN_LATENCY=0), data_set<=set_sel, wait counter<=0; in any other state, write pending slot.
REQ-017 Accepted start with set_sel>1 SHALL be discarded (no state change, pending untouched) and err SHALL pulse the following cycle.
REQ-018 start_ready SHALL equal ~pending_valid; start while start_ready=0 SHALL be ignored without err.
REQ-019 WAIT: wait counter increments on each non-stalled cycle; when it reaches DRAIN_LATENCY-1 on a non-stalled cycle, next state WRITE with matrix_index<=0.
REQ-020 WRITE: sram_write_enable = (state==WRITE) & ~stall, combinational; matrix_index increments after each non-stalled cycle; non-stalled cycle at index 2*ARRAY_SIZE-2 moves to DONE.
REQ-021 Stall SHALL hold state, wait counter, matrix_index and data_set; sram_write_enable low while stalled; stall ignored in IDLE and DONE.
REQ-022 DONE lasts exactly one cycle with done=1; next state WAIT (pending set loaded into data_set, pending cleared) if pending valid, else IDLE with matrix_index<=0.
REQ-023 A valid start in the DONE cycle with pending empty SHALL be treated as pending and launched directly to WAIT the next cycle.
REQ-024 matrix_index SHALL never exceed 2*ARRAY_SIZE-2 and SHALL not wrap within a tile.
REQ-025 Tile length: exactly 2*ARRAY_SIZE-1 cycles with sram_write_enable=1, indices strictly ascending, no gaps except stalls.

Reset
REQ-026 srstn=0 at a rising edge SHALL force IDLE, pending_valid=0, counters=0, data_set=0, matrix_index=0, done=0, err=0, sram_write_enable=0, busy=0, start_ready=1.
REQ-027 Reset mid-tile SHALL abort the tile with no further writes and no done pulse; start in the reset cycle SHALL be dropped.

Verification
REQ-028 ARRAY_SIZE=16, DRAIN_LATENCY=3, start+set_sel=0 at cycle 10 -> busy from 11, write enable 14..44 with index 0..30, done at 45, IDLE at 46.
REQ-029 Same, stall high cycles 20..22 -> index held at 6, enable low 20..22, last write at 47, done at 48.
REQ-030 start set 0 at 10, start set 1 at 15 -> start_ready low 16..45, second tile data_set=1 with first write at 49, done at 80.
REQ-031 start with set_sel=2 in IDLE -> err pulse next cycle, busy stays 0, no writes.
REQ-032 srstn low at cycle 30 of a running tile -> enable 0 and index 0 from cycle 31, no done, new start accepted at 32.
REQ-033 DRAIN_LATENCY=0, start at 10 -> first write at 11, done at 42.

Source files
------------

// File: rtl/write_out_sequencer.sv
// Sequences one diagonal write-out tile (2*ARRAY_SIZE-1 writes) after a drain delay.
// Latency: first write DRAIN_LATENCY+1 cycles after start acceptance; done one cycle after last write.
// Backpressure: stall freezes WAIT/WRITE in the same cycle; one-deep pending slot, start_ready = slot empty.
module write_out_sequencer #(
  parameter int ARRAY_SIZE    = 16,
  parameter int DRAIN_LATENCY = 3
) (
  input  logic       clk,
  input  logic       srstn,
  input  logic       start,
  input  logic [1:0] set_sel,
  input  logic       stall,
  output logic       start_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       sram_write_enable,
  output logic [1:0] data_set,
  output logic [5:0] matrix_index
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Last diagonal index of a tile and last wait-count value before writing starts.
  localparam logic [5:0] LAST_IDX  = 6'(2 * ARRAY_SIZE - 2);
  localparam logic [5:0] WAIT_LAST = 6'((DRAIN_LATENCY == 0) ? 0 : DRAIN_LATENCY - 1);
  // With no drain delay a tile goes straight into WRITE.
  localparam state_t     LAUNCH    = (DRAIN_LATENCY == 0) ? S_WRITE : S_WAIT;

  state_t     state_q, state_d;
  logic [5:0] wait_cnt_q, wait_cnt_d;
  logic [5:0] idx_q, idx_d;
  logic [1:0] set_q, set_d;
  logic       pend_vld_q, pend_vld_d;
  logic [1:0] pend_set_q, pend_set_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;

  logic       accept;
  logic       good_start;
  logic       bad_start;

  assign start_ready       = ~pend_vld_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign data_set          = set_q;
  assign matrix_index      = idx_q;
  assign sram_write_enable = (state_q == S_WRITE) & ~stall;

  // Next-state logic: FSM transitions, counters, pending slot and registered status outputs.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    set_d      = set_q;
    pend_vld_d = pend_vld_q;
    pend_set_d = pend_set_q;

    accept     = start & ~pend_vld_q;
    good_start = accept & (set_sel <= 2'd1);
    bad_start  = accept & (set_sel > 2'd1);
    err_d      = bad_start;

    case (state_q)
      S_IDLE: begin
        if (good_start) begin
          state_d    = LAUNCH;
          set_d      = set_sel;
          wait_cnt_d = '0;
          idx_d      = '0;
        end
      end
      S_WAIT: begin
        if (good_start) begin
          pend_vld_d = 1'b1;
          pend_set_d = set_sel;
        end
        if (!stall) begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = S_WRITE;
            idx_d   = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 6'd1;
          end
        end
      end
      S_WRITE: begin
        if (good_start) begin
          pend_vld_d = 1'b1;
          pend_set_d = set_sel;
        end
        if (!stall) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      S_DONE: begin
        // A start arriving in DONE with an empty slot launches exactly like a pending one.
        if (pend_vld_q) begin
          state_d    = LAUNCH;
          set_d      = pend_set_q;
          pend_vld_d = 1'b0;
          wait_cnt_d = '0;
          idx_d      = '0;
        end else if (good_start) begin
          state_d    = LAUNCH;
          set_d      = set_sel;
          wait_cnt_d = '0;
          idx_d      = '0;
        end else begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State registers with synchronous active-low reset; a reset cycle drops any start.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      set_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_set_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      set_q      <= set_d;
      pend_vld_q <= pend_vld_d;
      pend_set_q <= pend_set_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

endmodule
